// File: rtl/sd_cmdq_pkg.sv
// Shared types and constants for the SD command issue queue.
package sd_cmdq_pkg;
    localparam int CMD_W = 16;
    localparam int ARG_W = 32;
    localparam int RSP_W = 48;

    localparam int CICMD_BIT     = 0;
    localparam int CC_BIT        = 0;
    localparam int EI_BIT        = 15;
    localparam int ISSUE_TMO_BIT = 15;

    localparam logic [CMD_W-1:0] ERR_ISSUE_TMO = CMD_W'(1) << ISSUE_TMO_BIT;

    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_WAIT_BUSY = 5'b00010,
        S_WAIT_DONE = 5'b00100,
        S_RETIRE    = 5'b01000,
        S_CLEAR     = 5'b10000
    } cmdq_state_t;
endpackage

// File: rtl/sd_cmdq_fifo.sv
// First-word-fall-through FIFO with synchronous flush; used for both the
// command and response queues of sd_cmd_queue.
module sd_cmdq_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign w_do_rd = i_rd_en & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/sd_cmd_queue.sv
// Command issue queue in front of the SD command master: issues queued
// {CMD_SET, ARG} entries one at a time and collects {ERR_INT, RESP_1} results.
// Optional SD_CMDQ_HALT_ON_ERR_EN: a failed command halts issuing until q_flush.
module sd_cmd_queue
    import sd_cmdq_pkg::*;
#(
    parameter int CQ_DEPTH  = 4,
    parameter int RQ_DEPTH  = 4,
    parameter int ISSUE_TMO = 255
) (
    input  logic                        CLK_PAD_IO,
    input  logic                        RST_PAD_I,
    input  logic                        cq_wr_en,
    input  logic [CMD_W-1:0]            cq_wr_cmd,
    input  logic [ARG_W-1:0]            cq_wr_arg,
    output logic                        cq_full,
    output logic [$clog2(CQ_DEPTH):0]   cq_level,
    input  logic                        rq_rd_en,
    output logic [RSP_W-1:0]            rq_rd_data,
    output logic                        rq_empty,
    input  logic                        q_enable,
    input  logic                        q_flush,
    output logic                        q_busy,
    output logic                        New_CMD,
    output logic [CMD_W-1:0]            CMD_SET_REG,
    output logic [ARG_W-1:0]            ARG_REG,
    input  logic [15:0]                 STATUS_REG,
    input  logic [15:0]                 NORMAL_INT_REG,
    input  logic [15:0]                 ERR_INT_REG,
    input  logic [31:0]                 RESP_1_REG,
    output logic                        NORMAL_INT_RST,
    output logic                        ERR_INT_RST
`ifdef SD_CMDQ_HALT_ON_ERR_EN
    ,
    output logic                        q_halted
`endif
);
    localparam int TMO_W = $clog2(ISSUE_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ISSUE_TMO - 1);

    cmdq_state_t        r_state;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [RSP_W-1:0]   r_rsp;
    logic               r_new_cmd;
    logic               r_int_rst;
    logic [CMD_W-1:0]   r_cmd;
    logic [ARG_W-1:0]   r_arg;

    logic [RSP_W-1:0]   w_cq_head;
    logic               w_cq_empty;
    logic               w_rq_full;
    logic [$clog2(RQ_DEPTH):0] w_rq_level_unused;
    logic               w_issue;
    logic               w_rq_wr;
    logic               w_block;
    logic               w_in_bits_unused;

    assign w_in_bits_unused = ^{STATUS_REG[15:1], NORMAL_INT_REG[14:1]};

    // Flush takes priority over an issue so no discarded command can slip out.
    assign w_issue = (r_state == S_IDLE) & q_enable & ~w_cq_empty & ~q_flush
                   & ~STATUS_REG[CICMD_BIT] & ~w_block;
    assign w_rq_wr = (r_state == S_RETIRE) & ~w_rq_full;

    sd_cmdq_fifo #(.WIDTH(RSP_W), .DEPTH(CQ_DEPTH)) u_cmd_fifo (
        .i_clk     (CLK_PAD_IO),
        .i_rst     (RST_PAD_I),
        .i_flush   (q_flush),
        .i_wr_en   (cq_wr_en),
        .i_wr_data ({cq_wr_cmd, cq_wr_arg}),
        .i_rd_en   (w_issue),
        .o_rd_data (w_cq_head),
        .o_full    (cq_full),
        .o_empty   (w_cq_empty),
        .o_level   (cq_level)
    );

    sd_cmdq_fifo #(.WIDTH(RSP_W), .DEPTH(RQ_DEPTH)) u_rsp_fifo (
        .i_clk     (CLK_PAD_IO),
        .i_rst     (RST_PAD_I),
        .i_flush   (1'b0),
        .i_wr_en   (w_rq_wr),
        .i_wr_data (r_rsp),
        .i_rd_en   (rq_rd_en),
        .o_rd_data (rq_rd_data),
        .o_full    (w_rq_full),
        .o_empty   (rq_empty),
        .o_level   (w_rq_level_unused)
    );

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            r_rsp     <= '0;
            r_new_cmd <= 1'b0;
            r_int_rst <= 1'b0;
            r_cmd     <= '0;
            r_arg     <= '0;
        end else begin
            r_new_cmd <= 1'b0;
            r_int_rst <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_cmd     <= w_cq_head[RSP_W-1 -: CMD_W];
                        r_arg     <= w_cq_head[ARG_W-1:0];
                        r_new_cmd <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (STATUS_REG[CICMD_BIT]) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_rsp   <= {ERR_ISSUE_TMO, {ARG_W{1'b0}}};
                        r_state <= S_RETIRE;
                    end
                end
                S_WAIT_DONE: begin
                    if (NORMAL_INT_REG[CC_BIT] | NORMAL_INT_REG[EI_BIT]) begin
                        r_rsp   <= {ERR_INT_REG, RESP_1_REG};
                        r_state <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    if (!w_rq_full) begin
                        r_int_rst <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SD_CMDQ_HALT_ON_ERR_EN
    logic r_halted;

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I)
            r_halted <= 1'b0;
        else if (q_flush)
            r_halted <= 1'b0;
        else if (w_rq_wr && (r_rsp[RSP_W-1 -: CMD_W] != '0))
            r_halted <= 1'b1;
    end

    assign w_block  = r_halted;
    assign q_halted = r_halted;
`else
    assign w_block = 1'b0;
`endif

    assign q_busy         = (r_state != S_IDLE);
    assign New_CMD        = r_new_cmd;
    assign CMD_SET_REG    = r_cmd;
    assign ARG_REG        = r_arg;
    assign NORMAL_INT_RST = r_int_rst;
    assign ERR_INT_RST    = r_int_rst;
endmodule
